// File: rtl/aclock_pkg.sv
// Shared definitions for the alarm-clock time/alarm setting controller:
// state encoding, mode codes, digit indices and per-digit maxima.
package aclock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EDIT_T = 3'd1,
        ST_EDIT_A = 3'd2,
        ST_LOAD_T = 3'd3,
        ST_LOAD_A = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        MODE_IDLE       = 2'd0,
        MODE_EDIT_TIME  = 2'd1,
        MODE_EDIT_ALARM = 2'd2,
        MODE_LOAD       = 2'd3
    } mode_t;

    localparam logic [1:0] DIG_H1 = 2'd0;
    localparam logic [1:0] DIG_H0 = 2'd1;
    localparam logic [1:0] DIG_M1 = 2'd2;
    localparam logic [1:0] DIG_M0 = 2'd3;

    localparam logic [3:0] H1_MAX    = 4'd2;
    localparam logic [3:0] H0_MAX    = 4'd9;
    localparam logic [3:0] H0_MAX_H2 = 4'd3;
    localparam logic [3:0] M1_MAX    = 4'd5;
    localparam logic [3:0] M0_MAX    = 4'd9;

    function automatic logic [3:0] wrap_inc(input logic [3:0] val, input logic [3:0] max);
        return (val >= max) ? 4'd0 : val + 4'd1;
    endfunction

endpackage

// File: rtl/aclock_digit_inc.sv
// Combinational per-digit increment with wrap, keeping the edit value at or
// below 23:59 (hour units are clamped when the hour tens digit becomes 2).
module aclock_digit_inc
    import aclock_pkg::*;
(
    input  logic [1:0] sel,
    input  logic [1:0] h1,
    input  logic [3:0] h0,
    input  logic [3:0] m1,
    input  logic [3:0] m0,
    output logic [1:0] h1_nxt,
    output logic [3:0] h0_nxt,
    output logic [3:0] m1_nxt,
    output logic [3:0] m0_nxt
);

    always_comb begin
        h1_nxt = h1;
        h0_nxt = h0;
        m1_nxt = m1;
        m0_nxt = m0;
        case (sel)
            DIG_H1: begin
                h1_nxt = (h1 >= H1_MAX[1:0]) ? 2'd0 : h1 + 2'd1;
                if ((h1_nxt == H1_MAX[1:0]) && (h0 > H0_MAX_H2))
                    h0_nxt = H0_MAX_H2;
            end
            DIG_H0:  h0_nxt = wrap_inc(h0, (h1 == H1_MAX[1:0]) ? H0_MAX_H2 : H0_MAX);
            DIG_M1:  m1_nxt = wrap_inc(m1, M1_MAX);
            default: m0_nxt = wrap_inc(m0, M0_MAX);
        endcase
    end

endmodule

// File: rtl/aclock_set_ctrl.sv
// Button-driven editor for clock time and alarm; commits the edited digits to
// the clock core with a held load strobe.
//
// state     | meaning
// ST_IDLE   | no edit in progress, digits hold last value, waits for btn_mode
// ST_EDIT_T | editing the time, btn_next walks H1->H0->M1->M0 then commits
// ST_EDIT_A | editing the alarm, same navigation as ST_EDIT_T
// ST_LOAD_T | LD_time held for LOAD_CYCLES cycles, digits frozen
// ST_LOAD_A | LD_alarm held for LOAD_CYCLES cycles, digits frozen
module aclock_set_ctrl
    import aclock_pkg::*;
#(
    parameter int LOAD_CYCLES    = 10,
    parameter int TIMEOUT_CYCLES = 600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_inc,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic [1:0] mode,
    output logic [1:0] digit_sel
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LW = $clog2(LOAD_CYCLES + 1);
    localparam logic [TW-1:0] TMO_RELOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [LW-1:0] LD_RELOAD  = LW'(LOAD_CYCLES);

    state_t          state;
    logic [TW-1:0]   tmo_cnt;
    logic [LW-1:0]   ld_cnt;

    logic [1:0] h1_nxt;
    logic [3:0] h0_nxt;
    logic [3:0] m1_nxt;
    logic [3:0] m0_nxt;

    aclock_digit_inc u_digit_inc (
        .sel    (digit_sel),
        .h1     (H_in1),
        .h0     (H_in0),
        .m1     (M_in1),
        .m0     (M_in0),
        .h1_nxt (h1_nxt),
        .h0_nxt (h0_nxt),
        .m1_nxt (m1_nxt),
        .m0_nxt (m0_nxt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            H_in1     <= '0;
            H_in0     <= '0;
            M_in1     <= '0;
            M_in0     <= '0;
            LD_time   <= 1'b0;
            LD_alarm  <= 1'b0;
            mode      <= MODE_IDLE;
            digit_sel <= DIG_H1;
            tmo_cnt   <= '0;
            ld_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (btn_mode) begin
                        state     <= ST_EDIT_T;
                        mode      <= MODE_EDIT_TIME;
                        H_in1     <= '0;
                        H_in0     <= '0;
                        M_in1     <= '0;
                        M_in0     <= '0;
                        digit_sel <= DIG_H1;
                        tmo_cnt   <= TMO_RELOAD;
                    end
                end

                ST_EDIT_T, ST_EDIT_A: begin
                    // Button priority: mode over next over inc; the timeout
                    // down-counter reloads on any accepted button.
                    if (btn_mode) begin
                        digit_sel <= DIG_H1;
                        if (state == ST_EDIT_T) begin
                            state   <= ST_EDIT_A;
                            mode    <= MODE_EDIT_ALARM;
                            H_in1   <= '0;
                            H_in0   <= '0;
                            M_in1   <= '0;
                            M_in0   <= '0;
                            tmo_cnt <= TMO_RELOAD;
                        end else begin
                            state <= ST_IDLE;
                            mode  <= MODE_IDLE;
                        end
                    end else if (btn_next) begin
                        tmo_cnt <= TMO_RELOAD;
                        if (digit_sel != DIG_M0) begin
                            digit_sel <= digit_sel + 2'd1;
                        end else begin
                            state     <= (state == ST_EDIT_T) ? ST_LOAD_T : ST_LOAD_A;
                            mode      <= MODE_LOAD;
                            digit_sel <= DIG_H1;
                            ld_cnt    <= LD_RELOAD;
                        end
                    end else if (btn_inc) begin
                        tmo_cnt <= TMO_RELOAD;
                        H_in1   <= h1_nxt;
                        H_in0   <= h0_nxt;
                        M_in1   <= m1_nxt;
                        M_in0   <= m0_nxt;
                    end else if (tmo_cnt == '0) begin
                        state     <= ST_IDLE;
                        mode      <= MODE_IDLE;
                        digit_sel <= DIG_H1;
                    end else begin
                        tmo_cnt <= tmo_cnt - TW'(1);
                    end
                end

                ST_LOAD_T, ST_LOAD_A: begin
                    // Strobe rises the cycle after entry and stays for LOAD_CYCLES.
                    if (ld_cnt != '0) begin
                        LD_time  <= (state == ST_LOAD_T);
                        LD_alarm <= (state == ST_LOAD_A);
                        ld_cnt   <= ld_cnt - LW'(1);
                    end else begin
                        LD_time  <= 1'b0;
                        LD_alarm <= 1'b0;
                        state    <= ST_IDLE;
                        mode     <= MODE_IDLE;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    mode      <= MODE_IDLE;
                    digit_sel <= DIG_H1;
                    LD_time   <= 1'b0;
                    LD_alarm  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aclock_set_ctrl.sv
// Scoreboard bench for aclock_set_ctrl: a reference model predicts every cycle
// and queues each expected commit; a monitor checks each load strobe it sees.
module tb_aclock_set_ctrl;

    localparam int LOAD_CYCLES    = 10;
    localparam int TIMEOUT_CYCLES = 600;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_inc = 1'b0;
    logic [1:0] H_in1;
    logic [3:0] H_in0;
    logic [3:0] M_in1;
    logic [3:0] M_in0;
    logic       LD_time;
    logic       LD_alarm;
    logic [1:0] mode;
    logic [1:0] digit_sel;

    always #5 clk = ~clk;

    aclock_set_ctrl #(
        .LOAD_CYCLES    (LOAD_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_mode  (btn_mode),
        .btn_next  (btn_next),
        .btn_inc   (btn_inc),
        .H_in1     (H_in1),
        .H_in0     (H_in0),
        .M_in1     (M_in1),
        .M_in0     (M_in0),
        .LD_time   (LD_time),
        .LD_alarm  (LD_alarm),
        .mode      (mode),
        .digit_sel (digit_sel)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit alarm;
        int h1;
        int h0;
        int m1;
        int m0;
    } load_t;

    load_t exp_q[$];

    // Reference model: 0 idle, 1 editing time, 2 editing alarm, 3 loading
    int m_st;
    bit m_alarm;
    int m_d[4];
    int m_sel;
    int m_idle;
    int m_age;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0;
        m_alarm = 1'b0;
        for (int i = 0; i < 4; i++) m_d[i] = 0;
        m_sel = 0;
        m_idle = 0;
        m_age = 0;
    endtask

    task automatic model_clear_digits();
        for (int i = 0; i < 4; i++) m_d[i] = 0;
    endtask

    // Largest legal value of digit i given the current hour tens digit.
    function automatic int digit_limit(input int i);
        case (i)
            0:       return 2;
            1:       return (m_d[0] == 2) ? 3 : 9;
            2:       return 5;
            default: return 9;
        endcase
    endfunction

    task automatic model_bump(input int i);
        m_d[i] = (m_d[i] >= digit_limit(i)) ? 0 : m_d[i] + 1;
        if (m_d[0] * 10 + m_d[1] > 23) m_d[1] = 3;
    endtask

    task automatic model_clock(input bit bm, input bit bn, input bit bi);
        case (m_st)
            0: if (bm) begin
                m_st = 1; model_clear_digits(); m_sel = 0; m_idle = 0;
            end
            1, 2: begin
                if (bm) begin
                    if (m_st == 1) begin m_st = 2; model_clear_digits(); end
                    else m_st = 0;
                    m_sel = 0; m_idle = 0;
                end else if (bn) begin
                    m_idle = 0;
                    if (m_sel < 3) m_sel++;
                    else begin
                        m_alarm = (m_st == 2);
                        m_st = 3; m_age = 0; m_sel = 0;
                        exp_q.push_back(load_t'{m_alarm, m_d[0], m_d[1], m_d[2], m_d[3]});
                    end
                end else if (bi) begin
                    m_idle = 0;
                    model_bump(m_sel);
                end else if (m_idle == TIMEOUT_CYCLES - 1) begin
                    m_st = 0; m_sel = 0;
                end else begin
                    m_idle++;
                end
            end
            default: begin
                m_age++;
                if (m_age > LOAD_CYCLES) m_st = 0;
            end
        endcase
    endtask

    task automatic check_model();
        bit ld_on;
        ld_on = (m_st == 3) && (m_age >= 1);
        chk("mode", mode, m_st);
        chk("digit_sel", digit_sel, (m_st == 1 || m_st == 2) ? m_sel : 0);
        chk("H_in1", H_in1, m_d[0]);
        chk("H_in0", H_in0, m_d[1]);
        chk("M_in1", M_in1, m_d[2]);
        chk("M_in0", M_in0, m_d[3]);
        chk("LD_time", LD_time, int'(ld_on && !m_alarm));
        chk("LD_alarm", LD_alarm, int'(ld_on && m_alarm));
    endtask

    // Called at a point in the low clock phase; returns at the next negedge.
    task automatic step(input bit bm, input bit bn, input bit bi);
        btn_mode = bm;
        btn_next = bn;
        btn_inc  = bi;
        @(posedge clk);
        model_clock(bm, bn, bi);
        @(negedge clk);
        btn_mode = 1'b0;
        btn_next = 1'b0;
        btn_inc  = 1'b0;
        check_model();
    endtask

    task automatic incs(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1);
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    // Monitor: every strobe pulse must match a queued commit in kind, digits
    // and width, and the two strobes must never overlap.
    bit    mon_in_pulse = 1'b0;
    bit    mon_aborted  = 1'b0;
    int    mon_width    = 0;
    load_t mon_exp;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset && mon_in_pulse) mon_aborted = 1'b1;
            if (LD_time || LD_alarm) begin
                chk("ld_exclusive", int'(LD_time && LD_alarm), 0);
                if (!mon_in_pulse) begin
                    mon_in_pulse = 1'b1;
                    mon_aborted  = 1'b0;
                    mon_width    = 1;
                    chk("strobe_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) mon_exp = exp_q.pop_front();
                    else mon_exp = load_t'{1'b0, -1, -1, -1, -1};
                    chk("load_kind", LD_alarm, mon_exp.alarm);
                end else begin
                    mon_width++;
                end
                chk("load_h1", H_in1, mon_exp.h1);
                chk("load_h0", H_in0, mon_exp.h0);
                chk("load_m1", M_in1, mon_exp.m1);
                chk("load_m0", M_in0, mon_exp.m0);
            end else if (mon_in_pulse) begin
                mon_in_pulse = 1'b0;
                if (!mon_aborted) chk("load_width", mon_width, LOAD_CYCLES);
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_model();
        reset = 1'b1;

        // 12:34 into the time register
        step(1, 0, 0);
        incs(1); step(0, 1, 0);
        incs(2); step(0, 1, 0);
        incs(3); step(0, 1, 0);
        incs(4); step(0, 1, 0);
        chk("commit_mode", mode, 3);
        chk("commit_h", H_in1 * 10 + H_in0, 12);
        chk("commit_m", M_in1 * 10 + M_in0, 34);
        idles(LOAD_CYCLES + 3);
        chk("after_load_mode", mode, 0);
        chk("idle_hold_m0", M_in0, 4);

        // Hour units range shrinks to 0..3 once hour tens is 2; wraps on top
        step(1, 0, 0);
        incs(2); step(0, 1, 0);
        incs(3);
        chk("h0_at_3", H_in0, 3);
        incs(1);
        chk("h0_wrap", H_in0, 0);
        step(1, 0, 0);
        step(1, 0, 0);

        // 06:30 into the alarm register
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 1, 0);
        incs(6); step(0, 1, 0);
        incs(3); step(0, 1, 0);
        step(0, 1, 0);
        idles(LOAD_CYCLES + 3);

        // Edit abandoned after the idle timeout
        step(1, 0, 0);
        idles(TIMEOUT_CYCLES - 1);
        chk("pre_timeout_mode", mode, 1);
        idles(1);
        chk("timeout_mode", mode, 0);

        // Simultaneous buttons: mode wins
        step(1, 0, 0);
        incs(2); step(0, 1, 0); incs(1);
        step(1, 1, 1);
        chk("simul_mode", mode, 2);
        chk("simul_sel", digit_sel, 0);
        step(1, 0, 0);

        // Randomised button traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 2) == 0);
        step(1, 1, 0);
        idles(LOAD_CYCLES + 3);
        if (mode != 0) begin
            step(1, 0, 0);
            if (mode != 0) step(1, 0, 0);
        end

        // Reset in the middle of a time load
        step(1, 0, 0);
        incs(1); step(0, 1, 0);
        incs(5); step(0, 1, 0);
        incs(2); step(0, 1, 0);
        incs(7); step(0, 1, 0);
        idles(4);
        chk("ld_before_reset", LD_time, 1);
        #1;
        reset = 1'b0;
        #1;
        model_reset();
        chk("reset_ld_time", LD_time, 0);
        chk("reset_mode", mode, 0);
        chk("reset_digits", {H_in1, H_in0, M_in1, M_in0}, 0);
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;
        idles(LOAD_CYCLES + 5);

        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
